// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game engine.
package whack_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SPAWN  = 3'd1,
      ACTIVE = 3'd2,
      GAP    = 3'd3,
      DONE   = 3'd4
   } state_e;

   localparam int unsigned LFSR_W = 16;

   // Fibonacci LFSR seed; taps 16,14,13,11 map to bits 15,13,12,10.
   localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   // Active-low seven-segment patterns, bit order gfedcba.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // One shift of the LFSR: feedback is the XOR of the tapped bits.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// BCD digit to active-low seven-segment pattern; non-BCD codes blank the digit.
module seven_seg_decoder
   import whack_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   // Pattern lookup.
   always_comb begin
      seg_o = SEG_BLANK;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/whack_game_core.sv
// Whack-a-mole engine: LFSR mole placement, BCD scoring, lives, seven-segment score.
module whack_game_core
   import whack_pkg::*;
#(
   parameter int unsigned NUM_HOLES   = 18,
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned MOLE_CYCLES = 50000000,
   parameter int unsigned GAP_CYCLES  = 12500000,
   parameter int unsigned MAX_LIVES   = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [NUM_HOLES-1:0]    whacked,
   output logic [NUM_HOLES-1:0]    led,
   output logic [NUM_DIGITS*7-1:0] display,
   output logic [3:0]              lives,
   output logic                    game_over,
   output logic                    busy
);

   localparam int unsigned SW      = 4 * NUM_DIGITS;
   localparam int unsigned MAX_CYC = (MOLE_CYCLES > GAP_CYCLES) ? MOLE_CYCLES : GAP_CYCLES;
   localparam int unsigned TW      = $clog2(MAX_CYC);

   localparam logic [SW-1:0] SCORE_MAX = {NUM_DIGITS{4'd9}};
   localparam logic [3:0]    LIVES_INIT = 4'(MAX_LIVES);
   localparam logic [TW-1:0] MOLE_LOAD  = TW'(MOLE_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

   state_e                 state_q, state_d;
   logic [LFSR_W-1:0]      lfsr_q;
   logic [NUM_HOLES-1:0]   whacked_q;
   logic [NUM_HOLES-1:0]   led_q, led_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [SW-1:0]          score_q, score_d;
   logic [3:0]             lives_q, lives_d;
   logic                   game_over_q, busy_q;

   logic [NUM_HOLES-1:0]   rise_c;
   logic                   hit_c, miss_c, timeout_c, lose_c;
   logic [NUM_HOLES-1:0]   spawn_led_c;
   int unsigned            hole_c;
   logic [SW-1:0]          score_inc_c;
   logic                   carry_c;

   // Only fresh presses count; a held switch never re-triggers.
   assign rise_c    = whacked & ~whacked_q;
   assign hit_c     = |(rise_c & led_q);
   assign miss_c    = |(rise_c & ~led_q);
   assign timeout_c = (timer_q == '0);
   assign lose_c    = miss_c | timeout_c;

   // Mole placement from the current LFSR value.
   always_comb begin
      hole_c      = 32'(lfsr_q) % NUM_HOLES;
      spawn_led_c = '0;
      for (int unsigned i = 0; i < NUM_HOLES; i++) begin
         spawn_led_c[i] = (i == hole_c);
      end
   end

   // Saturating BCD increment with ripple carry.
   always_comb begin
      score_inc_c = score_q;
      carry_c     = 1'b1;
      if (score_q != SCORE_MAX) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (carry_c) begin
               if (score_q[4*i +: 4] == 4'd9) begin
                  score_inc_c[4*i +: 4] = 4'd0;
               end else begin
                  score_inc_c[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                  carry_c               = 1'b0;
               end
            end
         end
      end
   end

   // Game FSM next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      led_d   = led_q;
      timer_d = timer_q;
      score_d = score_q;
      lives_d = lives_q;
      case (state_q)
         IDLE: begin
            led_d = '0;
            if (start) begin
               score_d = '0;
               lives_d = LIVES_INIT;
               state_d = SPAWN;
            end
         end
         SPAWN: begin
            led_d   = spawn_led_c;
            timer_d = MOLE_LOAD;
            state_d = ACTIVE;
         end
         ACTIVE: begin
            if (hit_c) begin
               score_d = score_inc_c;
               led_d   = '0;
               timer_d = GAP_LOAD;
               state_d = GAP;
            end else begin
               // A miss and a timeout together still cost a single life.
               if (lose_c && (lives_q != 4'd0)) begin
                  lives_d = lives_q - 4'd1;
               end
               if (lose_c && (lives_q <= 4'd1)) begin
                  led_d   = '0;
                  state_d = DONE;
               end else if (timeout_c) begin
                  led_d   = '0;
                  timer_d = GAP_LOAD;
                  state_d = GAP;
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
         end
         GAP: begin
            led_d = '0;
            if (timeout_c) begin
               state_d = SPAWN;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         DONE: begin
            led_d = '0;
            if (start) begin
               score_d = '0;
               lives_d = LIVES_INIT;
               state_d = SPAWN;
            end
         end
         default: begin
            led_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         lfsr_q      <= LFSR_SEED;
         whacked_q   <= '0;
         led_q       <= '0;
         timer_q     <= '0;
         score_q     <= '0;
         lives_q     <= LIVES_INIT;
         game_over_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_step(lfsr_q);
         whacked_q   <= whacked;
         led_q       <= led_d;
         timer_q     <= timer_d;
         score_q     <= score_d;
         lives_q     <= lives_d;
         game_over_q <= (state_d == DONE);
         busy_q      <= (state_d == SPAWN) || (state_d == ACTIVE) || (state_d == GAP);
      end
   end

   // One decoder per score digit; digit 0 is least significant.
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      seven_seg_decoder u_seg (
         .bcd_i (score_q[4*g +: 4]),
         .seg_o (display[7*g +: 7])
      );
   end

   assign led       = led_q;
   assign lives     = lives_q;
   assign game_over = game_over_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_whack_game_core.sv
// Self-checking bench for whack_game_core with a small, fast game configuration.
module tb_whack_game_core;

   localparam int unsigned NH = 4;
   localparam int unsigned ND = 2;

   typedef enum int {A_NONE, A_HIT, A_WRONG, A_ALL} act_e;
   typedef enum int {L_ZERO, L_ONEHOT, L_SAME} led_e;

   typedef struct {
      act_e act;
      led_e led;
      int   lives;
      int   score;
      bit   go;
      bit   bsy;
   } vec_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [NH-1:0]   whacked;
   logic [NH-1:0]   led;
   logic [ND*7-1:0] display;
   logic [3:0]      lives;
   logic            game_over;
   logic            busy;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            step    = 0;
   logic [NH-1:0] lit_mask = 4'b0001;
   vec_t          sbq[$];
   vec_t          tbl[11];

   whack_game_core #(
      .NUM_HOLES   (NH),
      .NUM_DIGITS  (ND),
      .MOLE_CYCLES (8),
      .GAP_CYCLES  (2),
      .MAX_LIVES   (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .whacked   (whacked),
      .led       (led),
      .display   (display),
      .lives     (lives),
      .game_over (game_over),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [13:0] disp_of(input int s);
      return {seg(s / 10), seg(s % 10)};
   endfunction

   function automatic vec_t mk(input act_e a, input led_e l, input int lv, input int sc,
                               input bit go, input bit bs);
      vec_t v;
      v.act = a; v.led = l; v.lives = lv; v.score = sc; v.go = go; v.bsy = bs;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h expected %0h", nm, step, got, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic cyc(input logic rst, input logic st, input vec_t v);
      logic [NH-1:0] w;
      vec_t e;
      case (v.act)
         A_NONE:  w = '0;
         A_HIT:   w = lit_mask;
         A_WRONG: w = {lit_mask[NH-2:0], lit_mask[NH-1]};
         default: w = '1;
      endcase
      reset   = rst;
      start   = st;
      whacked = w;
      sbq.push_back(v);
      @(posedge clk);
      #1;
      step++;
      e = sbq.pop_front();
      case (e.led)
         L_ZERO:   chk("led_zero", 32'(led), 32'(0));
         L_ONEHOT: begin
            chk("led_onehot", 32'($countones(led)), 32'(1));
            lit_mask = led;
         end
         default:  chk("led_same", 32'(led), 32'(lit_mask));
      endcase
      chk("lives", 32'(lives), 32'(e.lives));
      chk("display", 32'(display), 32'(disp_of(e.score)));
      chk("game_over", 32'(game_over), 32'(e.go));
      chk("busy", 32'(busy), 32'(e.bsy));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      whacked = '0;

      // Hit, gap, respawn, then a held wrong switch charges only once.
      tbl[0]  = mk(A_HIT,   L_ZERO,   3, 1, 0, 1);
      tbl[1]  = mk(A_NONE,  L_ZERO,   3, 1, 0, 1);
      tbl[2]  = mk(A_NONE,  L_ZERO,   3, 1, 0, 1);
      tbl[3]  = mk(A_NONE,  L_ONEHOT, 3, 1, 0, 1);
      tbl[4]  = mk(A_WRONG, L_SAME,   2, 1, 0, 1);
      tbl[5]  = mk(A_WRONG, L_SAME,   2, 1, 0, 1);
      tbl[6]  = mk(A_WRONG, L_SAME,   2, 1, 0, 1);
      tbl[7]  = mk(A_WRONG, L_SAME,   2, 1, 0, 1);
      tbl[8]  = mk(A_WRONG, L_SAME,   2, 1, 0, 1);
      tbl[9]  = mk(A_NONE,  L_SAME,   2, 1, 0, 1);
      tbl[10] = mk(A_HIT,   L_ZERO,   2, 2, 0, 1);

      // Reset state, start, mole two edges after start.
      cyc(1'b1, 1'b0, mk(A_NONE, L_ZERO, 3, 0, 0, 0));
      cyc(1'b1, 1'b0, mk(A_NONE, L_ZERO, 3, 0, 0, 0));
      cyc(1'b0, 1'b1, mk(A_NONE, L_ZERO, 3, 0, 0, 1));
      cyc(1'b0, 1'b0, mk(A_NONE, L_ONEHOT, 3, 0, 0, 1));

      foreach (tbl[i]) cyc(1'b0, 1'b0, tbl[i]);

      // Three timeouts end the game; first one coincides with a wrong press.
      cyc(1'b1, 1'b0, mk(A_NONE, L_ZERO, 3, 0, 0, 0));
      cyc(1'b0, 1'b1, mk(A_NONE, L_ZERO, 3, 0, 0, 1));
      cyc(1'b0, 1'b0, mk(A_NONE, L_ONEHOT, 3, 0, 0, 1));
      cyc(1'b0, 1'b0, mk(A_HIT, L_ZERO, 3, 1, 0, 1));
      cyc(1'b0, 1'b0, mk(A_NONE, L_ZERO, 3, 1, 0, 1));
      cyc(1'b0, 1'b0, mk(A_NONE, L_ZERO, 3, 1, 0, 1));
      for (int m = 0; m < 3; m++) begin
         cyc(1'b0, 1'b0, mk(A_NONE, L_ONEHOT, 3 - m, 1, 0, 1));
         for (int k = 0; k < 7; k++) cyc(1'b0, 1'b0, mk(A_NONE, L_SAME, 3 - m, 1, 0, 1));
         cyc(1'b0, 1'b0, mk((m == 0) ? A_WRONG : A_NONE, L_ZERO, 2 - m, 1, m == 2, m != 2));
         if (m < 2) begin
            cyc(1'b0, 1'b0, mk(A_NONE, L_ZERO, 2 - m, 1, 0, 1));
            cyc(1'b0, 1'b0, mk(A_NONE, L_ZERO, 2 - m, 1, 0, 1));
         end
      end
      cyc(1'b0, 1'b0, mk(A_ALL,  L_ZERO, 0, 1, 1, 0));
      cyc(1'b0, 1'b0, mk(A_NONE, L_ZERO, 0, 1, 1, 0));
      cyc(1'b0, 1'b1, mk(A_NONE, L_ZERO, 3, 0, 0, 1));

      // Hit up to saturation, covering the 9 to 10 carry.
      for (int h = 1; h <= 100; h++) begin
         int prev;
         int now;
         prev = (h - 1 > 99) ? 99 : h - 1;
         now  = (h > 99) ? 99 : h;
         cyc(1'b0, 1'b0, mk(A_NONE, L_ONEHOT, 3, prev, 0, 1));
         cyc(1'b0, 1'b0, mk(A_HIT,  L_ZERO,   3, now,  0, 1));
         cyc(1'b0, 1'b0, mk(A_NONE, L_ZERO,   3, now,  0, 1));
         cyc(1'b0, 1'b0, mk(A_NONE, L_ZERO,   3, now,  0, 1));
      end

      // Reset during ACTIVE together with a hit edge.
      cyc(1'b0, 1'b0, mk(A_NONE, L_ONEHOT, 3, 99, 0, 1));
      cyc(1'b1, 1'b0, mk(A_HIT,  L_ZERO,   3, 0,  0, 0));
      cyc(1'b0, 1'b0, mk(A_NONE, L_ZERO,   3, 0,  0, 0));
      cyc(1'b0, 1'b1, mk(A_NONE, L_ZERO,   3, 0,  0, 1));
      cyc(1'b0, 1'b0, mk(A_NONE, L_ONEHOT, 3, 0,  0, 1));
      cyc(1'b0, 1'b0, mk(A_HIT,  L_ZERO,   3, 1,  0, 1));

      if (sbq.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard: got %0d left expected 0", sbq.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
